console_rx: RTL and testbench

- Console input path for the bbq core; it is the receive-side counterpart of the console_we/console_wdata output port.
- Deserialises an 8N1 UART stream from the host, buffers the received bytes in a FIFO, and presents them to the datapath through a read/valid interface (console_re, console_rvalid, console_rdata).
- Sits in bbq beside the dmem console mapping; the simulation bench drives rx from a bit-banged task.

---
 rtl/console_rx_pkg.sv | 26 ++
 rtl/console_rx_fifo.sv | 94 +++++++++
 rtl/console_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_console_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_rx_pkg.sv
// -----------------------------------------------------------------------------
// console_rx_pkg
//   Shared constants and types for the console receive path (console_rx) and
//   its FIFO. Holds the receiver FSM state encoding and UART frame constants.
// -----------------------------------------------------------------------------
package console_rx_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int RX_STATE_LEN   = 3;

    typedef enum logic [RX_STATE_LEN-1:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_PARITY    = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Even parity check: data bits plus parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// -----------------------------------------------------------------------------
// console_rx_fifo
//   Synchronous first-word-fall-through FIFO. rdata shows the head entry
//   combinationally from registered state and reads 0 while empty.
//   A pop is honoured only when non-empty; a push is honoured when not full,
//   or when full and a pop is honoured in the same cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-low
//   push   in   write wdata at the tail
//   wdata  in   [WIDTH-1:0] data to write
//   pop    in   remove the head entry
//   rdata  out  [WIDTH-1:0] head entry (0 when empty)
//   empty  out  no entries stored
//   full   out  DEPTH entries stored
// -----------------------------------------------------------------------------
module console_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // When full, the pop frees the head slot, which is exactly where wr_ptr
    // points, so pop-then-push keeps occupancy unchanged.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; empty/rdata gating
    // hides stale contents, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/console_rx.sv
// -----------------------------------------------------------------------------
// console_rx
//   Console input path for the bbq core. Deserialises a UART stream from the
//   host (8N1, or 8E1 when CONSOLE_RX_PARITY_EN is defined), buffers bytes in
//   a FWFT FIFO and presents them through a read/valid interface.
//
// Build option:
//   CONSOLE_RX_PARITY_EN  adds an even-parity bit between data and stop.
//                         Bad-parity bytes are not pushed and set
//                         parity_error. Undefined: parity_error tied to 0.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-low
//   rx              in   serial input, idle high, asynchronous to clk
//   console_re      in   pop the head byte (ignored while empty)
//   console_rdata   out  [XLEN-1:0] head byte zero-extended, 0 when empty
//   console_rvalid  out  FIFO non-empty
//   overrun         out  sticky: good byte dropped because FIFO full
//   frame_error     out  sticky: stop bit sampled low
//   parity_error    out  sticky: parity mismatch (0 without parity build)
//   err_clear       in   clears sticky flags; a same-cycle set wins
// -----------------------------------------------------------------------------
module console_rx
    import console_rx_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            console_re,
    output logic [XLEN-1:0] console_rdata,
    output logic            console_rvalid,
    output logic            overrun,
    output logic            frame_error,
    output logic            parity_error,
    input  logic            err_clear
);

    localparam int          CW       = $clog2(CLKS_PER_BIT);
    localparam int          BW       = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    // Two-flop synchroniser; idle level is high.
    logic rx_meta_q, rx_meta_d;
    logic rxs_q,     rxs_d;

    rx_state_e                 state_q, state_d;
    logic [CW-1:0]             cyc_q,   cyc_d;
    logic [BW-1:0]             bit_q,   bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_error_q, frame_error_d;

    logic                      push_req;
    logic                      set_fe;
    logic                      set_ov;
    logic                      pop_ok;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

`ifdef CONSOLE_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_error_q, parity_error_d;
    logic set_pe;
`endif

    assign rx_meta_d = rx;
    assign rxs_d     = rx_meta_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        set_fe   = 1'b0;
`ifdef CONSOLE_RX_PARITY_EN
        par_bad_d = par_bad_q;
        set_pe    = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    state_d = RX_START;
                    cyc_d   = '0;
                end
            end
            RX_START: begin
                // Re-check the line mid start bit to reject short glitches.
                if (cyc_q == CYC_MID) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? RX_IDLE : RX_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
`ifdef CONSOLE_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef CONSOLE_RX_PARITY_EN
            RX_PARITY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d     = '0;
                    par_bad_d = parity_bad(shift_q, rxs_q);
                    set_pe    = par_bad_d;
                    state_d   = RX_STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (rxs_q) begin
`ifdef CONSOLE_RX_PARITY_EN
                        push_req = !par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d  = RX_IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) reports once, then waits for idle.
                if (rxs_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign pop_ok = console_re && !fifo_empty;
    assign set_ov = push_req && fifo_full && !pop_ok;

    always_comb begin
        overrun_d     = set_ov ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
        frame_error_d = set_fe ? 1'b1 : (err_clear ? 1'b0 : frame_error_q);
`ifdef CONSOLE_RX_PARITY_EN
        parity_error_d = set_pe ? 1'b1 : (err_clear ? 1'b0 : parity_error_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= RX_IDLE;
            cyc_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rxs_q         <= rxs_d;
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

`ifdef CONSOLE_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bad_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            par_bad_q      <= par_bad_d;
            parity_error_q <= parity_error_d;
        end
    end
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    console_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (shift_q),
        .pop   (console_re),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign console_rvalid = !fifo_empty;
    assign console_rdata  = {{(XLEN-UART_DATA_BITS){1'b0}}, fifo_rdata};
    assign overrun        = overrun_q;
    assign frame_error    = frame_error_q;

endmodule

// File: tb/tb_console_rx.sv
// -----------------------------------------------------------------------------
// tb_console_rx
//   Directed bench for console_rx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Stimulus pushes the bytes it expects to be delivered into a scoreboard
//   queue; a monitor pops and compares whenever a read is honoured.
// -----------------------------------------------------------------------------
module tb_console_rx;

    localparam int XLEN = 32;
    localparam int CPB  = 4;
    localparam int DEP  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            rx = 1'b1;
    logic            console_re = 1'b0;
    logic            err_clear = 1'b0;
    logic [XLEN-1:0] console_rdata;
    logic            console_rvalid;
    logic            overrun;
    logic            frame_error;
    logic            parity_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] sb [$];

    always #5 clk = ~clk;

    console_rx #(
        .XLEN         (XLEN),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .console_re     (console_re),
        .console_rdata  (console_rdata),
        .console_rvalid (console_rvalid),
        .overrun        (overrun),
        .frame_error    (frame_error),
        .parity_error   (parity_error),
        .err_clear      (err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read is honoured at the coming edge; compare the head now.
    always @(negedge clk) begin
        if (reset && console_re && console_rvalid) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got 0x%08h expected no byte at %0t", console_rdata, $time);
            end else begin
                check("pop_data", console_rdata, {24'h0, sb.pop_front()});
            end
        end
    end

    // Drives one frame; returns just after the last edge of the stop bit,
    // i.e. one edge before the DUT samples the stop bit. rx is left at the
    // stop level.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
        int          nbits;
`ifdef CONSOLE_RX_PARITY_EN
        bits  = {stop_bit, (^data) ^ par_flip, data, 1'b0};
        nbits = 11;
`else
        bits  = {1'b0, stop_bit, data, 1'b0};
        nbits = 10;
        if (par_flip) bits[10] = 1'b0;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1;
        console_re = 1'b1;
        @(posedge clk);
        #1;
        console_re = 1'b0;
    endtask

    task automatic pulse_err_clear();
        @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", console_rvalid, 0);
        check("rst_rdata", console_rdata, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_overrun", overrun, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_parity_error", parity_error, 0);
        idle_bits(2);

        // Single byte: rvalid appears the cycle after the stop-sample edge
        sb.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b0);
        check("t1_rvalid_pre", console_rvalid, 0);
        @(posedge clk);
        #1;
        check("t1_rvalid_post", console_rvalid, 1);
        check("t1_rdata", console_rdata, 32'h0000_0041);
        pop_one();
        check("t1_rvalid_after_pop", console_rvalid, 0);
        check("t1_rdata_empty", console_rdata, 0);
        idle_bits(1);

        // Overrun: five bytes into a 4-deep FIFO
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        send_frame(8'h55, 1'b1, 1'b0); idle_bits(1);
        send_frame(8'hAA, 1'b1, 1'b0); idle_bits(1);
        send_frame(8'h00, 1'b1, 1'b0); idle_bits(1);
        send_frame(8'hFF, 1'b1, 1'b0); idle_bits(1);
        check("t2_overrun_before", overrun, 0);
        send_frame(8'h7E, 1'b1, 1'b0); idle_bits(1);
        check("t2_overrun", overrun, 1);
        check("t2_head", console_rdata, 32'h0000_0055);
        repeat (4) pop_one();
        check("t2_drained", console_rvalid, 0);
        check("t2_overrun_sticky", overrun, 1);

        // Glitch rejection: one cycle low
        @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        idle_bits(3);
        check("t3_glitch_no_byte", console_rvalid, 0);
        check("t3_glitch_no_error", frame_error, 0);

        // Frame error; err_clear coinciding with the set event
        send_frame(8'h12, 1'b0, 1'b0);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("t3_frame_error_wins", frame_error, 1);
        check("t3_overrun_cleared", overrun, 0);
        check("t3_no_push", console_rvalid, 0);
        pulse_err_clear();
        check("t3_fe_cleared", frame_error, 0);
        // Break: line held low, no further errors or bytes
        repeat (20 * CPB) @(posedge clk);
        #1;
        check("t3_break_one_error", frame_error, 0);
        check("t3_break_no_byte", console_rvalid, 0);
        idle_bits(3);
        sb.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1'b0);
        idle_bits(1);
        check("t3_recover", console_rdata, 32'h0000_0031);
        pop_one();

        // Full FIFO with pop coinciding with the stop sample
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
            idle_bits(1);
        end
        sb.push_back(8'h05);
        send_frame(8'h05, 1'b1, 1'b0);
        console_re = 1'b1;
        @(posedge clk);
        #1;
        console_re = 1'b0;
        idle_bits(1);
        check("t4_overrun", overrun, 0);
        check("t4_head", console_rdata, 32'h0000_0002);
        repeat (4) pop_one();
        check("t4_occupancy4", console_rvalid, 0);

        // Reset mid-frame with two bytes queued
        idle_bits(1);
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0); idle_bits(1);
        send_frame(8'h22, 1'b1, 1'b0); idle_bits(1);
        check("t5_queued", console_rvalid, 1);
        rx = 1'b0;                       // start bit of 0xC3
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;                       // bit0 of 0xC3
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;                       // bit1
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("t5_rvalid_reset", console_rvalid, 0);
        check("t5_rdata_reset", console_rdata, 0);
        idle_bits(3);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_bits(1);
        check("t5_rx_after_reset", console_rdata, 32'h0000_005A);
        pop_one();

`ifdef CONSOLE_RX_PARITY_EN
        // Parity: 0x03 has even parity 0
        send_frame(8'h03, 1'b1, 1'b1);
        idle_bits(1);
        check("t6_parity_error", parity_error, 1);
        check("t6_no_push", console_rvalid, 0);
        pulse_err_clear();
        check("t6_pe_cleared", parity_error, 0);
        sb.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        idle_bits(1);
        check("t6_good_parity", console_rdata, 32'h0000_0003);
        check("t6_no_error", parity_error, 0);
        pop_one();
`else
        check("t6_parity_tied", parity_error, 0);
`endif

        idle_bits(1);
        check("sb_drained", sb.size(), 0);
        check("final_empty", console_rvalid, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
